// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin_to_bcd_seq : iterative double-dabble binary -> packed BCD converter. |
// | Optional leading-zero blanking: LEADING_ZERO_BLANK_EN. Rev 1.0           |
// +--------------------------------------------------------------------------+
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_CNT_W = $clog2(BIN_W + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(BIN_W);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [BIN_W-1:0]   r_shreg;
  logic [c_BCD_W-1:0] r_scratch;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_BCD_W-1:0] r_bcd;
  logic               r_ovf;

  logic [c_BCD_W-1:0] w_adj;
  logic [c_BCD_W-1:0] w_scr_nxt;
  logic [BIN_W-1:0]   w_shreg_nxt;
  logic               w_carry_nxt;
  logic               w_last;
  logic [c_BCD_W-1:0] w_bcd_res;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                               r_scratch[4*i +: 4] + 4'd3 : r_scratch[4*i +: 4];
    end
  endgenerate

  // The bit leaving the top digit means the value no longer fits in DIGITS.
  assign w_scr_nxt   = {w_adj[c_BCD_W-2:0], r_shreg[BIN_W-1]};
  assign w_shreg_nxt = r_shreg << 1;
  assign w_carry_nxt = r_carry | w_adj[c_BCD_W-1];
  assign w_last      = (r_cnt == c_CNT_W'(1));
  assign w_bcd_res   = w_carry_nxt ? {DIGITS{4'h9}} : w_scr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_shreg   <= '0;
      r_scratch <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_shreg   <= bin_in;
            r_scratch <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= c_CNT_INIT;
            r_state   <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          r_scratch <= w_scr_nxt;
          r_shreg   <= w_shreg_nxt;
          r_carry   <= w_carry_nxt;
          r_cnt     <= r_cnt - 1'b1;
          if (w_last) begin
            r_bcd   <= w_bcd_res;
            r_ovf   <= w_carry_nxt;
            r_state <= c_DONE;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_res;
  logic              w_hi_zero;

  // Digit 0 is never blanked so a zero result still shows "0".
  always_comb begin
    w_blank_res = '0;
    w_hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_hi_zero      = w_hi_zero & (w_scr_nxt[4*i +: 4] == 4'd0);
      w_blank_res[i] = w_hi_zero & ~w_carry_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank <= '0;
    end else if ((r_state == c_SHIFT) && w_last) begin
      r_blank <= w_blank_res;
    end
  end

  assign blank_mask = r_blank;
`else
  assign blank_mask = '0;
`endif

  assign busy     = (r_state == c_SHIFT);
  assign done     = (r_state == c_DONE);
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;

endmodule
`default_nettype wire
